// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcode and state
// encodings plus helpers that locate the instruction fields for a given
// instruction width.
package cpu_defs;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_AND   = 3'd1,
    OP_NOT   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_STORE = 3'd4,
    OP_JUMP  = 3'd5,
    OP_JUMPZ = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_IDLE      = 3'd6,
    S_PAUSE     = 3'd7
  } state_e;

  // Opcode occupies the top three bits.
  function automatic int opc_msb(input int instr_w);
    return instr_w - 1;
  endfunction

  // Register-select bit sits directly below the opcode.
  function automatic int reg_pos(input int instr_w);
    return instr_w - 4;
  endfunction

  // Everything below the register-select bit is the offset field.
  function automatic int off_width(input int instr_w);
    return instr_w - 4;
  endfunction

  function automatic logic is_alu_op(input opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Memory-port handshake between the control sequencer (master) and the
// memory-port muxes / memory (slave).
interface control_fsm_if #(
  parameter int OFF_W = 4
);
  logic             mem_req;
  logic             mem_we;
  logic             mem_sel;
  logic             addr_sel;
  logic [OFF_W-1:0] addr_offset;
  logic             mem_ready;

  modport master (
    output mem_req, mem_we, mem_sel, addr_sel, addr_offset,
    input  mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_sel, addr_sel, addr_offset,
    output mem_ready
  );
endinterface

// File: rtl/control_fsm_retire_counter.sv
// Retired-instruction counter: increments on each retirement pulse and
// wraps naturally at 2^CNT_W.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count retirements; async reset clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Control sequencer for the 8-bit CPU. Holds the state register and decodes
// every datapath strobe from state, instr, zf and mem_ready.
//
// state      | meaning
// FETCH      | request instruction at PC; on ready load IR and bump PC
// DECODE     | choose execute / memory / halt path from the opcode
// EXECUTE    | ALU operation or (conditional) jump
// MEMORY     | load/store at PC+offset, held until mem_ready
// WRITEBACK  | write A or B from ALU or memory; retires
// HALT_STATE | halted until resume
// IDLE       | retirement slot for jumps and stores
// PAUSE      | single-step hold until step
module control_fsm
  import cpu_defs::*;
#(
  parameter int  INSTR_W = 8,
  parameter int  CNT_W   = 16,
  localparam int OFF_W   = off_width(INSTR_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zf,
  input  logic               step_mode,
  input  logic               step,
  input  logic               resume,
  control_fsm_if.master      mem,
  output logic [2:0]         state,
  output logic               pc_we,
  output logic               pc_sel,
  output logic               pc_jmp_sel,
  output logic [OFF_W-1:0]   pc_offset,
  output logic [2:0]         alu_opcode,
  output logic               alu_sel_a,
  output logic               alu_sel_b,
  output logic               alu_we,
  output logic               zf_we,
  output logic               ir_we,
  output logic               a_sel,
  output logic               a_we,
  output logic               b_sel,
  output logic               b_we,
  output logic               halt,
  output logic               instr_done,
  output logic [CNT_W-1:0]   retired_count
);

  localparam int OPC_MSB = opc_msb(INSTR_W);
  localparam int REG_POS = reg_pos(INSTR_W);

  state_e           st, st_nxt;
  opcode_e          op;
  logic             reg_bit;
  logic [OFF_W-1:0] offset;

  assign op      = opcode_e'(instr[OPC_MSB -: 3]);
  assign reg_bit = instr[REG_POS];
  assign offset  = instr[OFF_W-1:0];
  assign state   = st;

  // State register; async reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= S_FETCH;
    end else begin
      st <= st_nxt;
    end
  end

  // Next-state and strobe decode; everything stays low while reset is high.
  always_comb begin
    st_nxt          = st;
    pc_we           = 1'b0;
    pc_sel          = 1'b0;
    pc_jmp_sel      = 1'b0;
    pc_offset       = '0;
    mem.mem_req     = 1'b0;
    mem.mem_we      = 1'b0;
    mem.mem_sel     = 1'b0;
    mem.addr_sel    = 1'b0;
    mem.addr_offset = '0;
    alu_opcode      = 3'd0;
    alu_sel_a       = 1'b0;
    alu_sel_b       = 1'b0;
    alu_we          = 1'b0;
    zf_we           = 1'b0;
    ir_we           = 1'b0;
    a_sel           = 1'b0;
    a_we            = 1'b0;
    b_sel           = 1'b0;
    b_we            = 1'b0;
    halt            = 1'b0;
    instr_done      = 1'b0;
    if (!reset) begin
      unique case (st)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            pc_we  = 1'b1;
            ir_we  = 1'b1;
            st_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: st_nxt = S_MEMORY;
            OP_HALT:           st_nxt = S_HALT;
            default:           st_nxt = S_EXECUTE;
          endcase
        end
        S_EXECUTE: begin
          if (is_alu_op(op)) begin
            alu_opcode = op;
            alu_sel_a  = offset[OFF_W-1];
            alu_sel_b  = (op == OP_NOT) ? 1'b0 : offset[OFF_W-2];
            alu_we     = 1'b1;
            zf_we      = 1'b1;
            st_nxt     = S_WRITEBACK;
          end else begin
            if ((op == OP_JUMP) || ((op == OP_JUMPZ) && zf)) begin
              pc_we      = 1'b1;
              pc_sel     = 1'b1;
              pc_jmp_sel = reg_bit;
              pc_offset  = offset;
            end
            st_nxt = S_IDLE;
          end
        end
        S_MEMORY: begin
          mem.mem_req     = 1'b1;
          mem.addr_sel    = 1'b1;
          mem.addr_offset = offset;
          if (op == OP_STORE) begin
            mem.mem_we  = 1'b1;
            mem.mem_sel = reg_bit;
          end
          if (mem.mem_ready) begin
            st_nxt = (op == OP_STORE) ? S_IDLE : S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          // ALU results select the ALU path; loads take memory data.
          if (reg_bit) begin
            b_we  = 1'b1;
            b_sel = is_alu_op(op);
          end else begin
            a_we  = 1'b1;
            a_sel = is_alu_op(op);
          end
          instr_done = 1'b1;
          st_nxt     = step_mode ? S_PAUSE : S_FETCH;
        end
        S_IDLE: begin
          instr_done = 1'b1;
          st_nxt     = step_mode ? S_PAUSE : S_FETCH;
        end
        S_PAUSE: begin
          if (step || !step_mode) begin
            st_nxt = S_FETCH;
          end
        end
        S_HALT: begin
          halt = 1'b1;
          if (resume) begin
            st_nxt = S_FETCH;
          end
        end
      endcase
    end
  end

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .en    (instr_done),
    .count (retired_count)
  );

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: instruction-level reference model checked every
// cycle, directed scenarios with literal expectations, randomized traffic,
// and a second wide-instruction instance with a narrow counter for wrap.
module tb_control_fsm;
  import cpu_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, reset2;

  // ---------------- DUT 1: INSTR_W=8, CNT_W=16 ----------------
  logic [7:0]  instr;
  logic        zf, step_mode, step, resume;
  logic [2:0]  state;
  logic        pc_we, pc_sel, pc_jmp_sel;
  logic [3:0]  pc_offset;
  logic [2:0]  alu_opcode;
  logic        alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
  logic        a_sel, a_we, b_sel, b_we, halt, instr_done;
  logic [15:0] retired_count;

  control_fsm_if #(.OFF_W(4)) m1 ();

  control_fsm #(.INSTR_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zf(zf), .step_mode(step_mode),
    .step(step), .resume(resume), .mem(m1), .state(state), .pc_we(pc_we),
    .pc_sel(pc_sel), .pc_jmp_sel(pc_jmp_sel), .pc_offset(pc_offset),
    .alu_opcode(alu_opcode), .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b),
    .alu_we(alu_we), .zf_we(zf_we), .ir_we(ir_we), .a_sel(a_sel), .a_we(a_we),
    .b_sel(b_sel), .b_we(b_we), .halt(halt), .instr_done(instr_done),
    .retired_count(retired_count)
  );

  // ---------------- DUT 2: INSTR_W=12, CNT_W=4 ----------------
  logic [11:0] instr2;
  logic        zf2, step_mode2, step2, resume2;
  logic [2:0]  state2;
  logic        pc_we2, pc_sel2, pc_jmp_sel2;
  logic [7:0]  pc_offset2;
  logic [2:0]  alu_opcode2;
  logic        alu_sel_a2, alu_sel_b2, alu_we2, zf_we2, ir_we2;
  logic        a_sel2, a_we2, b_sel2, b_we2, halt2, instr_done2;
  logic [3:0]  retired_count2;

  control_fsm_if #(.OFF_W(8)) m2 ();

  control_fsm #(.INSTR_W(12), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .instr(instr2), .zf(zf2), .step_mode(step_mode2),
    .step(step2), .resume(resume2), .mem(m2), .state(state2), .pc_we(pc_we2),
    .pc_sel(pc_sel2), .pc_jmp_sel(pc_jmp_sel2), .pc_offset(pc_offset2),
    .alu_opcode(alu_opcode2), .alu_sel_a(alu_sel_a2), .alu_sel_b(alu_sel_b2),
    .alu_we(alu_we2), .zf_we(zf_we2), .ir_we(ir_we2), .a_sel(a_sel2), .a_we(a_we2),
    .b_sel(b_sel2), .b_we(b_we2), .halt(halt2), .instr_done(instr_done2),
    .retired_count(retired_count2)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       pc_we, pc_sel, pc_jmp_sel;
    logic [3:0] pc_offset;
    logic       mem_req, mem_we, mem_sel, addr_sel;
    logic [3:0] addr_offset;
    logic [2:0] alu_opcode;
    logic       alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
    logic       a_sel, a_we, b_sel, b_we, halt, instr_done;
  } strb_t;

  int          mst;      // model phase, numbered as the documented states
  int unsigned mcnt;     // model retired count
  logic [7:0]  iq[$];    // instructions to load at the next DECODE
  int          nvec = 0;
  int          nfail = 0;

  function automatic strb_t model_out(input int s, input logic [7:0] ins,
                                      input logic z, input logic rdy, input logic rst);
    strb_t      o   = '0;
    int         op  = int'(ins[7:5]);
    logic       r   = ins[4];
    logic [3:0] off = ins[3:0];
    bit         alu = (op <= 2);
    if (rst) return o;
    case (s)
      0: begin
        o.mem_req = 1'b1;
        if (rdy) begin o.pc_we = 1'b1; o.ir_we = 1'b1; end
      end
      2: begin
        if (alu) begin
          o.alu_opcode = 3'(op);
          o.alu_sel_a  = off[3];
          o.alu_sel_b  = (op == 2) ? 1'b0 : off[2];
          o.alu_we     = 1'b1;
          o.zf_we      = 1'b1;
        end else if (op == 5 || (op == 6 && z)) begin
          o.pc_we = 1'b1; o.pc_sel = 1'b1; o.pc_jmp_sel = r; o.pc_offset = off;
        end
      end
      3: begin
        o.mem_req = 1'b1; o.addr_sel = 1'b1; o.addr_offset = off;
        if (op == 4) begin o.mem_we = 1'b1; o.mem_sel = r; end
      end
      4: begin
        o.instr_done = 1'b1;
        if (r) begin o.b_we = 1'b1; o.b_sel = alu; end
        else   begin o.a_we = 1'b1; o.a_sel = alu; end
      end
      5: o.halt = 1'b1;
      6: o.instr_done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic int model_next(input int s, input logic [7:0] ins, input logic rdy,
                                    input logic sm, input logic stp, input logic res);
    int op = int'(ins[7:5]);
    case (s)
      0: return rdy ? 1 : 0;
      1: return (op == 3 || op == 4) ? 3 : (op == 7) ? 5 : 2;
      2: return (op <= 2) ? 4 : 6;
      3: return rdy ? ((op == 4) ? 6 : 4) : 3;
      4, 6: return sm ? 7 : 0;
      5: return res ? 0 : 5;
      default: return (stp || !sm) ? 0 : 7;
    endcase
  endfunction

  function automatic strb_t dut_out();
    strb_t o;
    o.pc_we = pc_we; o.pc_sel = pc_sel; o.pc_jmp_sel = pc_jmp_sel; o.pc_offset = pc_offset;
    o.mem_req = m1.mem_req; o.mem_we = m1.mem_we; o.mem_sel = m1.mem_sel;
    o.addr_sel = m1.addr_sel; o.addr_offset = m1.addr_offset;
    o.alu_opcode = alu_opcode; o.alu_sel_a = alu_sel_a; o.alu_sel_b = alu_sel_b;
    o.alu_we = alu_we; o.zf_we = zf_we; o.ir_we = ir_we;
    o.a_sel = a_sel; o.a_we = a_we; o.b_sel = b_sel; o.b_we = b_we;
    o.halt = halt; o.instr_done = instr_done;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive this cycle's inputs (mid-cycle), then compare DUT against model.
  task automatic apply(input logic rdy, input logic z, input logic sm,
                       input logic stp, input logic res);
    m1.mem_ready = rdy; zf = z; step_mode = sm; step = stp; resume = res;
    if (!reset && mst == 1) begin
      if (iq.size() > 0) instr = iq.pop_front();
      else               instr = 8'($urandom);
    end
    #1;
    chk("state", 64'(state), 64'(mst));
    chk("strobes", 64'(dut_out()), 64'(model_out(mst, instr, zf, m1.mem_ready, reset)));
    chk("count", 64'(retired_count), 64'(mcnt));
  endtask

  // Advance the model across one rising edge, land on the falling edge.
  task automatic step_edge();
    @(posedge clk);
    if (reset) begin
      mst = 0; mcnt = 0;
    end else begin
      if (mst == 4 || mst == 6) mcnt = (mcnt + 1) % 65536;
      mst = model_next(mst, instr, m1.mem_ready, step_mode, step, resume);
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic rdy, input logic z, input logic sm,
                     input logic stp, input logic res);
    step_edge();
    apply(rdy, z, sm, stp, res);
  endtask

  int   hold_cnt;
  int   seq2[4] = '{0, 1, 2, 6};
  logic sm_r;
  int   k;

  initial begin
    reset = 1'b0; reset2 = 1'b0;
    instr = 8'h00; zf = 1'b0; step_mode = 1'b0; step = 1'b0; resume = 1'b0;
    m1.mem_ready = 1'b0;
    instr2 = 12'hBA5; zf2 = 1'b0; step_mode2 = 1'b0; step2 = 1'b0; resume2 = 1'b0;
    m2.mem_ready = 1'b1;
    mst = 0; mcnt = 0;
    iq.push_back(8'h0C);  // ADD  A <- A+B
    iq.push_back(8'h75);  // LOAD B, offset 5
    iq.push_back(8'hC9);  // JUMPz reg A, offset 9 (zf=0)
    iq.push_back(8'hD6);  // JUMPz reg B, offset 6 (zf=1)
    iq.push_back(8'h93);  // STORE B, offset 3
    iq.push_back(8'hE0);  // HALT
    #2;
    reset = 1'b1; reset2 = 1'b1;
    @(negedge clk);

    // reset: everything low
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_any_output", 64'(|{dut_out(), retired_count}), 64'(0));
    step_edge(); apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step_edge();
    reset = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_fetch_req", 64'(m1.mem_req), 64'(1));

    // ADD: F-D-E-W
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("add_decode", 64'(state), 64'(1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("add_execute", 64'(state), 64'(2));
    chk("add_alu_we", 64'(alu_we), 64'(1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("add_writeback", 64'(state), 64'(4));
    chk("add_a_sel_we", 64'({a_sel, a_we}), 64'(3));
    chk("add_count_before", 64'(retired_count), 64'(0));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("add_count_after", 64'(retired_count), 64'(1));
    chk("model_count_pin", 64'(mcnt), 64'(1));

    // LOAD B offset 5 with three wait cycles in MEMORY
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("load_mem_state", 64'(state), 64'(3));
      chk("load_mem_addr", 64'({m1.addr_sel, m1.addr_offset}), 64'(5'h15));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("load_wb_b", 64'({b_we, b_sel, a_we}), 64'(3'b100));

    // JUMPz not taken, then taken
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("jz0_pc_we", 64'(pc_we), 64'(0));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("jz0_idle_done", 64'({state, instr_done}), 64'({3'd6, 1'b1}));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("jz1_jump", 64'({pc_we, pc_sel, pc_jmp_sel, pc_offset}), 64'({3'b111, 4'd6}));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("jz1_idle_done", 64'(instr_done), 64'(1));

    // STORE under single-step
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("store_mem_we", 64'({state, m1.mem_we, m1.mem_sel}), 64'({3'd3, 2'b11}));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("store_idle", 64'({state, m1.mem_we}), 64'({3'd6, 1'b0}));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); chk("pause_hold", 64'(state), 64'(7));
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1); chk("pause_step", 64'(state), 64'(7));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("pause_exit", 64'(state), 64'(0));

    // HALT then resume
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("halt_enter", 64'({state, halt}), 64'({3'd5, 1'b1}));
    hold_cnt = int'(retired_count);
    chk("halt_count_pin", 64'(hold_cnt), 64'(5));
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("halt_hold", 64'({halt, retired_count}), 64'({1'b1, 16'(hold_cnt)}));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); chk("halt_resume_cycle", 64'(halt), 64'(1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); chk("halt_to_fetch", 64'({state, halt}), 64'(0));

    // randomized traffic
    sm_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) sm_r = ~sm_r;
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), sm_r,
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    // async reset in the middle of a LOAD's MEMORY phase
    iq.delete();
    iq.push_back(8'h7A);
    k = 0;
    while (k < 200 && mst != 3) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      k++;
    end
    chk("reach_memory", 64'(state), 64'(3));
    #2;
    reset = 1'b1; mst = 0; mcnt = 0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_state", 64'(state), 64'(0));
    chk("midrst_outputs", 64'(|{dut_out(), retired_count}), 64'(0));
    step_edge();
    reset = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_count", 64'(retired_count), 64'(0));

    // wide instruction, narrow counter: JUMP reg B offset 0xA5, wraps at 16
    #1;
    chk("dut2_rst_state", 64'(state2), 64'(0));
    chk("dut2_rst_outputs", 64'(|{pc_we2, pc_sel2, pc_jmp_sel2, pc_offset2, m2.mem_req,
        m2.mem_we, m2.mem_sel, m2.addr_sel, m2.addr_offset, alu_opcode2, alu_sel_a2,
        alu_sel_b2, alu_we2, zf_we2, ir_we2, a_sel2, a_we2, b_sel2, b_we2, halt2,
        instr_done2, retired_count2}), 64'(0));
    reset2 = 1'b0;
    #1;
    for (int i = 0; i < 17; i++) begin
      for (int p = 0; p < 4; p++) begin
        chk("dut2_state", 64'(state2), 64'(seq2[p]));
        if (p == 2) chk("dut2_jump", 64'({pc_we2, pc_jmp_sel2, pc_offset2}), 64'({2'b11, 8'hA5}));
        @(negedge clk); #1;
      end
      chk("dut2_count", 64'(retired_count2), 64'((i + 1) % 16));
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("dut2_pre_rst", 64'({state2, pc_we2}), 64'({3'd2, 1'b1}));
    reset2 = 1'b1;
    #1;
    chk("dut2_midrst", 64'(|{state2, pc_we2, pc_sel2, pc_offset2, retired_count2}), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
